// File: rtl/charlieplex_led_ctrl.sv
// Charlieplexed LED scanner: NPINS pins drive NPINS*(NPINS-1) LEDs, configured over WISHBONE.
// Define CHARLIEPLEX_PWM_EN to add the BRIGHT register and a 4-bit PWM subcounter in the lit window.
module charlieplex_led_ctrl #(
  parameter int NPINS     = 4,
  parameter int DWELL     = 1024,
  parameter int DEADTIME  = 16,
  parameter int BLINK_BIT = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  input  logic [NPINS*(NPINS-1)-1:0] internal_led_i,
  output logic [NPINS-1:0]           led_out_o,
  output logic [NPINS-1:0]           led_oe_o
);
  localparam int NLEDS = NPINS * (NPINS - 1);
  localparam int SW    = $clog2(NLEDS);
  localparam int DW    = $clog2(DWELL);
  localparam int BW    = BLINK_BIT + 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NLEDS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_LIT} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             enable_q, enable_d;
  logic [NLEDS-1:0] override_q, override_d;
  logic [NLEDS-1:0] value_q, value_d;
  logic [NLEDS-1:0] blink_q, blink_d;
  logic             eff_lat_q, eff_lat_d;
  logic [NPINS-1:0] oe_q, oe_d;
  logic [NPINS-1:0] out_q, out_d;
  logic             ack_q, ack_d;
`ifdef CHARLIEPLEX_PWM_EN
  logic [3:0]       bright_q, bright_d;
  logic [3:0]       sub_q, sub_d;
`endif

  logic [NLEDS-1:0] eff;
  logic             wr_en;
  logic             drive;
  int               a_i, r_i, b_i;
  logic             unused_ok;

  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i[4:2])
      3'd0: wb_dat_o = {8'(NPINS), 8'(NLEDS), 15'd0, enable_q};
      3'd1: wb_dat_o[NLEDS-1:0] = override_q;
      3'd2: wb_dat_o[NLEDS-1:0] = value_q;
      3'd3: wb_dat_o[NLEDS-1:0] = blink_q;
`ifdef CHARLIEPLEX_PWM_EN
      3'd4: wb_dat_o[3:0] = bright_q;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    dwell_d     = dwell_q;
    enable_d    = enable_q;
    override_d  = override_q;
    value_d     = value_q;
    blink_d     = blink_q;
    eff_lat_d   = eff_lat_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
`ifdef CHARLIEPLEX_PWM_EN
    bright_d    = bright_q;
    sub_d       = (state_q == S_LIT) ? sub_q + 4'd1 : 4'd0;
`endif

    ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_en = ack_d & wb_we_i;
    if (wr_en) begin
      case (wb_adr_i[4:2])
        3'd0: enable_d   = wb_dat_i[0];
        3'd1: override_d = wb_dat_i[NLEDS-1:0];
        3'd2: value_d    = wb_dat_i[NLEDS-1:0];
        3'd3: blink_d    = wb_dat_i[NLEDS-1:0];
`ifdef CHARLIEPLEX_PWM_EN
        3'd4: bright_d   = wb_dat_i[3:0];
`endif
        default: ;
      endcase
    end

    eff = ((override_q & value_q) | (~override_q & internal_led_i))
          & (~blink_q | {NLEDS{blink_cnt_q[BLINK_BIT]}});

    case (state_q)
      S_IDLE: begin
        slot_d  = '0;
        dwell_d = '0;
        if (enable_q) state_d = S_DEAD;
      end
      S_DEAD: begin
        // Latch once per slot so mid-slot updates cannot glitch the pins.
        if (dwell_q == '0) eff_lat_d = eff[slot_q];
        dwell_d = dwell_q + DW'(1);
        if (dwell_q == DEAD_LAST) state_d = S_LIT;
      end
      S_LIT: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
          state_d = S_DEAD;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable_q) begin
      state_d = S_IDLE;
      slot_d  = '0;
      dwell_d = '0;
    end

    // Slot k -> (a, b): a = k / (NPINS-1), b skips over a.
    a_i   = int'(slot_q) / (NPINS - 1);
    r_i   = int'(slot_q) % (NPINS - 1);
    b_i   = (r_i < a_i) ? r_i : r_i + 1;
    drive = enable_q && (state_q == S_LIT) && eff_lat_q;
`ifdef CHARLIEPLEX_PWM_EN
    drive = drive && (sub_q <= bright_q);
`endif
    oe_d  = '0;
    out_d = '0;
    if (drive) begin
      oe_d  = (NPINS'(1) << a_i) | (NPINS'(1) << b_i);
      out_d = NPINS'(1) << a_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_DEAD;
      slot_q      <= '0;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      enable_q    <= 1'b1;
      override_q  <= '0;
      value_q     <= '0;
      blink_q     <= '0;
      eff_lat_q   <= 1'b0;
      oe_q        <= '0;
      out_q       <= '0;
      ack_q       <= 1'b0;
`ifdef CHARLIEPLEX_PWM_EN
      bright_q    <= 4'hF;
      sub_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      enable_q    <= enable_d;
      override_q  <= override_d;
      value_q     <= value_d;
      blink_q     <= blink_d;
      eff_lat_q   <= eff_lat_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      ack_q       <= ack_d;
`ifdef CHARLIEPLEX_PWM_EN
      bright_q    <= bright_d;
      sub_q       <= sub_d;
`endif
    end
  end

  assign wb_ack_o  = ack_q & wb_cyc_i;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign led_oe_o  = oe_q;
  assign led_out_o = out_q;

endmodule

// File: doc/charlieplex_led_ctrl.md
Name:
charlieplex_led_ctrl

Overview:
Parametrised charlieplexed LED scanner with a WISHBONE register interface. It generalises the fixed 4-pin / 12-LED LED charlieplexer to NPINS pins driving NPINS*(NPINS-1) LEDs. It adds per-LED override, per-LED blink, per-slot dead time against ghosting, and glitch-free slot latching. It sits inside the board ID/control block and drives the board LED pins via top-level tristate buffers.

Parameters:
NPINS, 4, charlieplex pin count; legal 2..6, so NLEDS = NPINS*(NPINS-1) <= 30 (derived localparam).
DWELL, 1024, clocks per LED slot; must be >= DEADTIME+2.
DEADTIME, 16, clocks at start of each slot with all pins released.
BLINK_BIT, 24, bit of the free-running counter used as blink phase.

Ports:
clk_i  in  1  system clock; all logic in this domain.
rst_i  in  1  synchronous, active-low reset.
wb_cyc_i  in  1  WISHBONE cycle.
wb_stb_i  in  1  WISHBONE strobe.
wb_we_i  in  1  WISHBONE write enable.
wb_adr_i  in  5  byte address; only [4:2] decoded.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data.
wb_ack_o  out  1  acknowledge.
wb_err_o  out  1  tied 0.
wb_rty_o  out  1  tied 0.
internal_led_i  in  NLEDS  LED requests from firmware logic.
led_out_o  out  NPINS  pin drive values.
led_oe_o  out  NPINS  pin output enables, active-high; 0 = Z.

Behaviour:
- Reset (rst_i=0 at clk edge):
  - CTRL.enable=1; OVERRIDE, VALUE, BLINK = 0; BRIGHT=0xF.
  - Slot, dwell and blink counters = 0.
  - led_oe_o=0, led_out_o=0, wb_ack_o=0.
- WISHBONE:
  - wb_ack_o registered: asserts the cycle after cyc&stb while ack is low; 1-cycle pulse; gated by wb_cyc_i.
  - Writes commit on the ack cycle. wb_dat_o is combinational from the address.
- Register map (reg bits above NLEDS read 0):
  - 0x00 CTRL: bit0 enable (RW); [23:16] NLEDS (RO); [31:24] NPINS (RO).
  - 0x04 OVERRIDE [NLEDS-1:0]: 1 = use VALUE bit instead of internal_led_i.
  - 0x08 VALUE [NLEDS-1:0].
  - 0x0C BLINK [NLEDS-1:0]: 1 = gate LED with blink phase.
  - 0x10 BRIGHT [3:0]: see optional feature.
  - 0x14-0x1C: read 0, writes ignored.
- Effective vector: eff[i] = (OVERRIDE[i] ? VALUE[i] : internal_led_i[i]) & (~BLINK[i] | blink_phase).
- Slot mapping: slot k enumerates ordered pairs (a,b), a outer 0..NPINS-1, b inner 0..NPINS-1, skipping b=a. For NPINS=4: slot0=(0,1), slot1=(0,2), slot2=(0,3), slot3=(1,0), ... slot11=(3,2).
- Scan FSM:
  - IDLE: enable=0. Counters held 0; oe=0.
  - DEAD: dwell 0..DEADTIME-1. oe=0. On dwell==DEADTIME-1, go to LIT.
  - LIT: oe[a]=oe[b]=1, out[a]=1, out[b]=0, others oe=0, if the slot's latched eff bit is set; otherwise oe=0.
  - At dwell==DWELL-1: dwell->0, slot increments; wrap NLEDS-1 -> 0; go to DEAD.
- eff[slot] is sampled into a latch on the first DEAD cycle of each slot. Register writes or internal_led_i changes mid-slot do not affect the pins until the next slot.
- Outputs are registered: 1-cycle latency from FSM state to pins.
- enable 1->0: next cycle oe=0 and FSM enters IDLE.
- enable 0->1: scan starts at slot0, DEAD.
- Write to OVERRIDE and VALUE in consecutive transactions: the combined effect is visible from the next slot boundary.
- Reset mid-slot: pins released on the following edge.
- Blink counter is free-running and unaffected by enable.

Optional Feature:
CHARLIEPLEX_PWM_EN
- With the macro: a 4-bit subcounter runs in LIT. The pin pair is driven only while subcounter <= BRIGHT; BRIGHT=0xF means always on, 0x0 means 1/16 duty.
- Without the macro: BRIGHT reads 0, writes are ignored, and LIT drives for the full window.

Test Plan:
1. Reset, NPINS=4, DWELL=32, DEADTIME=4, internal_led_i=12'h001 -> cycles 0-4 oe=0; then oe=4'b0011, out=4'b0001 for 28 cycles; oe=0 in slots 1-11; pattern repeats every 384 cycles.
2. Write OVERRIDE=0x800, VALUE=0x800 mid-slot 3 -> no pin change until the slot-11 LIT window: oe=4'b1100, out=4'b1000. Read 0x04 returns 0x00000800 with a 1-cycle ack.
3. Write CTRL=0 during LIT -> oe=0 the next cycle. Re-enable -> first lit window is slot0 after DEADTIME.
4. BLINK=0x001, BLINK_BIT=6, internal_led_i=1 -> slot0 lit only while blink counter bit6=1; alternate 64-cycle phases dark.
5. Read 0x00 -> 0x040C0001. Read 0x18 -> 0. Write 0x18 -> no register change.
6. CHARLIEPLEX_PWM_EN, BRIGHT=3 -> in LIT, pins driven 4 of every 16 cycles. Without the macro, BRIGHT reads 0 and LIT is driven continuously.
